grostl_sbox_sched: RTL and testbench

GROSTL_SBOX_SCHED -- requirements
Module: grostl_sbox_sched

---
 rtl/grostl_pkg.sv | 32 +++
 rtl/grostl_sbox_lut.sv | 11 +
 rtl/grostl_sbox_sched.sv | 92 +++++++++
 tb/tb_grostl_sbox_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grostl_pkg.sv
// Shared types and the Grostl/AES S-box table for the SubBytes scheduler.
package grostl_pkg;

  typedef logic [0:7][0:7][7:0] grostl_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } grostl_sched_state_t;

  // Entry 0 sits in the most significant byte, so SBOX[x] is S(x).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/grostl_sbox_lut.sv
// One combinational S-box lane.
module grostl_sbox_lut
  import grostl_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/grostl_sbox_sched.sv
// Time-multiplexed SubBytes over the 8x8 Grostl state using NSBOX shared lanes.
module grostl_sbox_sched
  import grostl_pkg::*;
#(
  parameter int NSBOX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  grostl_state_t din,
  output logic          out_valid,
  input  logic          out_ready,
  output grostl_state_t dout,
  output logic          busy,
  output logic          trig
);

  localparam int NGROUP = 64 / NSBOX;
  localparam int GW     = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam logic [GW-1:0] GLAST = GW'(NGROUP - 1);

  grostl_sched_state_t state_p0, state_d;
  logic [GW-1:0]       g_p0;
  grostl_state_t       mat_p0;

  logic [7:0] lane_in  [NSBOX];
  logic [7:0] lane_out [NSBOX];
  logic [2:0] lane_row [NSBOX];
  logic [2:0] lane_col [NSBOX];

  // Flat byte i = g*NSBOX+k walks down columns: row = i%8, col = i/8.
  always_comb begin
    logic [5:0] idx;
    idx = '0;
    for (int k = 0; k < NSBOX; k++) begin
      idx         = 6'(int'(g_p0) * NSBOX + k);
      lane_row[k] = idx[2:0];
      lane_col[k] = idx[5:3];
      lane_in[k]  = mat_p0[idx[2:0]][idx[5:3]];
    end
  end

  for (genvar k = 0; k < NSBOX; k++) begin : g_lane
    grostl_sbox_lut u_lut (
      .a(lane_in[k]),
      .y(lane_out[k])
    );
  end

  always_comb begin
    state_d = state_p0;
    unique case (state_p0)
      ST_IDLE: if (in_valid)      state_d = ST_RUN;
      ST_RUN:  if (g_p0 == GLAST) state_d = ST_DONE;
      ST_DONE: if (out_ready)     state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Working matrix is cleared on reset so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_IDLE;
      g_p0     <= '0;
      mat_p0   <= '0;
    end else begin
      state_p0 <= state_d;
      case (state_p0)
        ST_IDLE: begin
          if (in_valid) begin
            mat_p0 <= din;
            g_p0   <= '0;
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NSBOX; k++)
            mat_p0[lane_row[k]][lane_col[k]] <= lane_out[k];
          g_p0 <= (g_p0 == GLAST) ? '0 : g_p0 + GW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_p0 == ST_IDLE);
  assign busy      = (state_p0 == ST_RUN);
  assign out_valid = (state_p0 == ST_DONE);
  assign trig      = (state_p0 == ST_RUN) && (g_p0 == '0);
  assign dout      = mat_p0;

endmodule

// File: tb/tb_grostl_sbox_sched.sv
// Directed bench for grostl_sbox_sched across lane counts 8, 1, 2, 4 and 64.
`timescale 1ns/1ps
module tb_grostl_sbox_sched;
  import grostl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic iv [5];
  logic ir [5];
  logic ov [5];
  logic ordy [5];
  logic bs [5];
  logic tr [5];
  grostl_state_t dn [5];
  grostl_state_t dt [5];

  grostl_sbox_sched #(.NSBOX(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .din(dn[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .dout(dt[0]), .busy(bs[0]), .trig(tr[0]));
  grostl_sbox_sched #(.NSBOX(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .din(dn[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .dout(dt[1]), .busy(bs[1]), .trig(tr[1]));
  grostl_sbox_sched #(.NSBOX(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .din(dn[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .dout(dt[2]), .busy(bs[2]), .trig(tr[2]));
  grostl_sbox_sched #(.NSBOX(4)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .din(dn[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .dout(dt[3]), .busy(bs[3]), .trig(tr[3]));
  grostl_sbox_sched #(.NSBOX(64)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]), .din(dn[4]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .dout(dt[4]), .busy(bs[4]), .trig(tr[4]));

  int nvec = 0;
  int nmis = 0;
  logic [7:0] model_tab [256];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference S-box built from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    logic hi;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1b;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic grostl_state_t sub_m(input grostl_state_t m);
    grostl_state_t o;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        o[r][c] = model_tab[m[r][c]];
    return o;
  endfunction

  // kind 0: every byte = seed; kind 1: byte[r][c] = 8*c + r + seed
  function automatic grostl_state_t mk(input int kind, input logic [7:0] seed);
    grostl_state_t m;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = (kind == 0) ? seed : 8'(8 * c + r) + seed;
    return m;
  endfunction

  // Call just after a falling edge; returns edges until out_valid and trig cycles.
  task automatic do_op(input int u, input grostl_state_t m, output int lat, output int trigs);
    dn[u] = m;
    iv[u] = 1'b1;
    chk("in_ready_at_accept", 512'(ir[u]), 512'(1));
    @(posedge clk); #1;
    iv[u] = 1'b0;
    lat = 0;
    trigs = 0;
    while (!ov[u] && lat < 200) begin
      if (tr[u]) trigs++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input int u);
    ordy[u] = 1'b1;
    @(posedge clk); #1;
    ordy[u] = 1'b0;
    chk("idle_after_handshake_in_ready", 512'(ir[u]), 512'(1));
    chk("idle_after_handshake_out_valid", 512'(ov[u]), 512'(0));
  endtask

  task automatic b2b(input int u, input int space);
    grostl_state_t ins [3];
    int acc_c [3];
    int na, nr, cyc;
    logic a, r;
    ins[0] = mk(0, 8'h01);
    ins[1] = mk(1, 8'h40);
    ins[2] = mk(0, 8'h53);
    na = 0; nr = 0; cyc = 0;
    acc_c = '{0, 0, 0};
    ordy[u] = 1'b1;
    @(negedge clk);
    dn[u] = ins[0];
    iv[u] = 1'b1;
    while ((na < 3 || nr < 3) && cyc < 400) begin
      a = iv[u] && ir[u];
      r = ov[u] && ordy[u];
      if (r && nr < 3) begin
        chk($sformatf("b2b_u%0d_result%0d", u, nr), dt[u], sub_m(ins[nr]));
        nr++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (a) begin
        acc_c[na] = cyc;
        na++;
        if (na < 3) dn[u] = ins[na];
        else iv[u] = 1'b0;
      end
    end
    iv[u] = 1'b0;
    ordy[u] = 1'b0;
    chk($sformatf("b2b_u%0d_accepts", u), 512'(na), 512'(3));
    chk($sformatf("b2b_u%0d_results", u), 512'(nr), 512'(3));
    chk($sformatf("b2b_u%0d_spacing01", u), 512'(acc_c[1] - acc_c[0]), 512'(space));
    chk($sformatf("b2b_u%0d_spacing12", u), 512'(acc_c[2] - acc_c[1]), 512'(space));
  endtask

  typedef struct {
    int         u;
    int         kind;
    logic [7:0] seed;
    int         lat;
    logic [7:0] b10;
  } vec_t;

  initial begin
    vec_t tv [6];
    grostl_state_t m;
    int lat, trigs;

    tv[0] = '{0, 0, 8'h00,  8, 8'h63};
    tv[1] = '{1, 1, 8'h00, 64, 8'h7c};
    tv[2] = '{2, 1, 8'h40, 32, 8'h83};
    tv[3] = '{3, 1, 8'h80, 16, 8'h0c};
    tv[4] = '{4, 1, 8'hc0,  1, 8'h78};
    tv[5] = '{0, 0, 8'h53,  8, 8'hed};

    for (int i = 0; i < 256; i++) model_tab[i] = sbox_ref(8'(i));

    for (int j = 0; j < 5; j++) begin
      iv[j] = 1'b0;
      ordy[j] = 1'b0;
      dn[j] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("reset_u%0d_in_ready", j), 512'(ir[j]), 512'(1));
      chk($sformatf("reset_u%0d_out_valid", j), 512'(ov[j]), 512'(0));
      chk($sformatf("reset_u%0d_busy", j), 512'(bs[j]), 512'(0));
      chk($sformatf("reset_u%0d_trig", j), 512'(tr[j]), 512'(0));
      chk($sformatf("reset_u%0d_dout", j), dt[j], 512'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m = mk(tv[i].kind, tv[i].seed);
      do_op(tv[i].u, m, lat, trigs);
      chk($sformatf("vec%0d_latency", i), 512'(lat), 512'(tv[i].lat));
      chk($sformatf("vec%0d_trig_cycles", i), 512'(trigs), 512'(1));
      chk($sformatf("vec%0d_trig_low_in_done", i), 512'(tr[tv[i].u]), 512'(0));
      chk($sformatf("vec%0d_dout", i), dt[tv[i].u], sub_m(m));
      chk($sformatf("vec%0d_dout10", i), 512'(dt[tv[i].u][1][0]), 512'(tv[i].b10));
      release_out(tv[i].u);
    end

    // Output held under backpressure; in_valid in DONE must be ignored.
    @(negedge clk);
    m = mk(1, 8'h10);
    do_op(0, m, lat, trigs);
    chk("hold_latency", 512'(lat), 512'(8));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dn[0] = ~m;
      iv[0] = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_dout", i), dt[0], sub_m(m));
      chk($sformatf("hold%0d_out_valid", i), 512'(ov[0]), 512'(1));
      chk($sformatf("hold%0d_in_ready", i), 512'(ir[0]), 512'(0));
    end
    @(negedge clk);
    iv[0] = 1'b0;
    release_out(0);
    chk("hold_after_release_dout", dt[0], sub_m(m));
    chk("hold_after_release_busy", 512'(bs[0]), 512'(0));

    // Asynchronous abort in the middle of RUN.
    @(negedge clk);
    dn[0] = mk(0, 8'haa);
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_g_before", 512'(u0.g_p0), 512'(3));
    chk("abort_busy_before", 512'(bs[0]), 512'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 512'(ov[0]), 512'(0));
    chk("abort_in_ready", 512'(ir[0]), 512'(1));
    chk("abort_busy", 512'(bs[0]), 512'(0));
    chk("abort_g", 512'(u0.g_p0), 512'(0));
    chk("abort_dout_zero", dt[0], 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, mk(0, 8'h53), lat, trigs);
    chk("post_abort_latency", 512'(lat), 512'(8));
    chk("post_abort_dout_ed", dt[0], mk(0, 8'hed));
    release_out(0);

    // Back-to-back streams with out_ready tied high.
    b2b(0, 10);
    b2b(4, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
